// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the integer register file and its scoreboard.
package regfile_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SIZE_DEF  = 32;

  function automatic int idx_w(input int size);
    return $clog2(size);
  endfunction

  // Pending vector for the default configuration; bit 0 is unused since x0 is never pending.
  typedef logic [SIZE_DEF-1:0] pending_vec_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: claim sets, writeback clears, and read ports report readiness.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int SIZE   = SIZE_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int BYPASS = 1,
  parameter int IW     = idx_w(SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR*IW-1:0] wr_index_i,
  input  logic                 claim_en_i,
  input  logic [IW-1:0]        claim_index_i,
  input  logic [NUM_RD-1:0]    rd_en_i,
  input  logic [NUM_RD*IW-1:0] rd_index_i,
  output logic [NUM_RD-1:0]    rd_ready_o,
  output logic                 sb_empty_o
);

  // Zero-extend before comparing so non-power-of-two sizes reject the upper indices.
  function automatic logic idx_ok(input logic [IW-1:0] idx);
    return (idx != '0) && ({{(32-IW){1'b0}}, idx} < 32'(SIZE));
  endfunction

  logic [SIZE-1:1]   pending_q, pending_d;
  logic [NUM_WR-1:0] wr_vld;

  always_comb begin
    for (int p = 0; p < NUM_WR; p++)
      wr_vld[p] = wr_en_i[p] && idx_ok(wr_index_i[p*IW +: IW]);
  end

  // Claim is applied after the clears so a same-cycle claim+write leaves the register pending.
  always_comb begin
    pending_d = pending_q;
    for (int p = 0; p < NUM_WR; p++)
      if (wr_vld[p]) pending_d[wr_index_i[p*IW +: IW]] = 1'b0;
    if (claim_en_i && idx_ok(claim_index_i)) pending_d[claim_index_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [IW-1:0] idx;
    logic          hit;
    logic          rdy;

    assign idx = rd_index_i[r*IW +: IW];

    always_comb begin
      hit = 1'b0;
      for (int p = 0; p < NUM_WR; p++)
        if (wr_vld[p] && wr_index_i[p*IW +: IW] == idx) hit = 1'b1;
    end

    always_comb begin
      rdy = 1'b1;
      if (rd_en_i[r] && idx_ok(idx))
        rdy = (BYPASS != 0 && hit) ? 1'b1 : !pending_q[idx];
    end

    assign rd_ready_o[r] = rdy;
  end

  assign sb_empty_o = ~|pending_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file (x0 hardwired to zero) with an integrated hazard scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int SIZE   = SIZE_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int BYPASS = 1,
  localparam int IW    = idx_w(SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_WR-1:0]       wr_en_i,
  input  logic [NUM_WR*IW-1:0]    wr_index_i,
  input  logic [NUM_WR*WIDTH-1:0] wr_data_i,
  input  logic [NUM_RD-1:0]       rd_en_i,
  input  logic [NUM_RD*IW-1:0]    rd_index_i,
  output logic [NUM_RD*WIDTH-1:0] rd_data_o,
  output logic [NUM_RD-1:0]       rd_ready_o,
  input  logic                    claim_en_i,
  input  logic [IW-1:0]           claim_index_i,
  output logic                    sb_empty_o
);

  function automatic logic idx_ok(input logic [IW-1:0] idx);
    return (idx != '0) && ({{(32-IW){1'b0}}, idx} < 32'(SIZE));
  endfunction

  logic [SIZE-1:1][WIDTH-1:0] regs_q, regs_d;
  logic [NUM_WR-1:0]          wr_vld;

  always_comb begin
    for (int p = 0; p < NUM_WR; p++)
      wr_vld[p] = wr_en_i[p] && idx_ok(wr_index_i[p*IW +: IW]);
  end

  // Ascending port order: the highest-numbered port writing an index wins.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NUM_WR; p++)
      if (wr_vld[p]) regs_d[wr_index_i[p*IW +: IW]] = wr_data_i[p*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] data;

    assign idx = rd_index_i[r*IW +: IW];

    always_comb begin
      data = '0;
      if (rd_en_i[r] && idx_ok(idx)) begin
        data = regs_q[idx];
        if (BYPASS != 0)
          for (int p = 0; p < NUM_WR; p++)
            if (wr_vld[p] && wr_index_i[p*IW +: IW] == idx) data = wr_data_i[p*WIDTH +: WIDTH];
      end
    end

    assign rd_data_o[r*WIDTH +: WIDTH] = data;
  end

  regfile_scoreboard #(
    .SIZE   (SIZE),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR),
    .BYPASS (BYPASS),
    .IW     (IW)
  ) u_sb (
    .clk           (clk),
    .reset         (reset),
    .wr_en_i       (wr_en_i),
    .wr_index_i    (wr_index_i),
    .claim_en_i    (claim_en_i),
    .claim_index_i (claim_index_i),
    .rd_en_i       (rd_en_i),
    .rd_index_i    (rd_index_i),
    .rd_ready_o    (rd_ready_o),
    .sb_empty_o    (sb_empty_o)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks of regfile_sb: one bypassing 32-entry instance and one non-bypassing 24-entry instance.
module tb_regfile_sb;

  localparam int W  = 32;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    wr_en;
  logic [2*IW-1:0] wr_index;
  logic [2*W-1:0]  wr_data;
  logic [1:0]    rd_en;
  logic [2*IW-1:0] rd_index;
  logic          claim_en;
  logic [IW-1:0] claim_index;

  logic [2*W-1:0] rd_data_a, rd_data_b;
  logic [1:0]     rd_ready_a, rd_ready_b;
  logic           sb_empty_a, sb_empty_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(W), .SIZE(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_a (
    .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_index_i(wr_index), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_index_i(rd_index), .rd_data_o(rd_data_a), .rd_ready_o(rd_ready_a),
    .claim_en_i(claim_en), .claim_index_i(claim_index), .sb_empty_o(sb_empty_a));

  regfile_sb #(.WIDTH(W), .SIZE(24), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_index_i(wr_index), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_index_i(rd_index), .rd_data_o(rd_data_b), .rd_ready_o(rd_ready_b),
    .claim_en_i(claim_en), .claim_index_i(claim_index), .sb_empty_o(sb_empty_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_index = '0; wr_data = '0; claim_en = 1'b0; claim_index = '0;
  endtask

  task automatic wr(input int p, input logic [IW-1:0] idx, input logic [W-1:0] d);
    wr_en[p] = 1'b1; wr_index[p*IW +: IW] = idx; wr_data[p*W +: W] = d;
  endtask

  task automatic rd(input logic [IW-1:0] i0, input logic [IW-1:0] i1);
    rd_en = 2'b11; rd_index = {i1, i0};
  endtask

  initial begin
    idle();
    reset = 1'b1;
    rd(5, 5);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_data_a", rd_data_a, 64'h0);
    chk("rst_data_b", rd_data_b, 64'h0);
    chk("rst_rdy_a", rd_ready_a, 2'b11);
    chk("rst_rdy_b", rd_ready_b, 2'b11);
    chk("rst_empty", {sb_empty_a, sb_empty_b}, 2'b11);

    // x5 write: bypass visible same cycle only on instance A
    wr(0, 5, 32'hDEADBEEF);
    #1;
    chk("byp_w5_a", rd_data_a, {32'hDEADBEEF, 32'hDEADBEEF});
    chk("nobyp_w5_b", rd_data_b, 64'h0);
    tick(); idle();
    #1;
    chk("w5_a", rd_data_a, {32'hDEADBEEF, 32'hDEADBEEF});
    chk("w5_b", rd_data_b, {32'hDEADBEEF, 32'hDEADBEEF});
    chk("w5_rdy", {rd_ready_a, rd_ready_b}, 4'b1111);
    rd_en = 2'b01;
    #1;
    chk("rden0_a", rd_data_a, {32'h0, 32'hDEADBEEF});
    chk("rden0_rdy", {rd_ready_a, rd_ready_b}, 4'b1111);

    // x0 write and claim are discarded
    wr(0, 0, 32'h1234); claim_en = 1'b1; claim_index = 0;
    rd(0, 0);
    #1;
    chk("x0_same_a", rd_data_a, 64'h0);
    tick(); idle();
    #1;
    chk("x0_a", rd_data_a, 64'h0);
    chk("x0_b", rd_data_b, 64'h0);
    chk("x0_rdy", {rd_ready_a, rd_ready_b}, 4'b1111);
    chk("x0_empty", {sb_empty_a, sb_empty_b}, 2'b11);

    // claim x7: no same-cycle effect, pending next cycle
    claim_en = 1'b1; claim_index = 7;
    rd(7, 0);
    #1;
    chk("clm7_same_rdy", {rd_ready_a, rd_ready_b}, 4'b1111);
    chk("clm7_same_empty", {sb_empty_a, sb_empty_b}, 2'b11);
    tick(); idle();
    #1;
    chk("clm7_rdy", {rd_ready_a, rd_ready_b}, 4'b1010);
    chk("clm7_empty", {sb_empty_a, sb_empty_b}, 2'b00);
    wr(0, 7, 32'hA5A5A5A5);
    #1;
    chk("wb7_byp_data_a", rd_data_a[31:0], 32'hA5A5A5A5);
    chk("wb7_nobyp_data_b", rd_data_b[31:0], 32'h0);
    chk("wb7_rdy", {rd_ready_a, rd_ready_b}, 4'b1110);
    chk("wb7_empty_nolook", {sb_empty_a, sb_empty_b}, 2'b00);
    tick(); idle();
    #1;
    chk("wb7_data", {rd_data_a[31:0], rd_data_b[31:0]}, {32'hA5A5A5A5, 32'hA5A5A5A5});
    chk("wb7_rdy_after", {rd_ready_a, rd_ready_b}, 4'b1111);
    chk("wb7_empty_after", {sb_empty_a, sb_empty_b}, 2'b11);

    // claim and write x9 together: data lands, stays pending
    claim_en = 1'b1; claim_index = 9; wr(0, 9, 32'h11);
    rd(9, 0);
    tick(); idle();
    #1;
    chk("cw9_data", {rd_data_a[31:0], rd_data_b[31:0]}, {32'h11, 32'h11});
    chk("cw9_rdy", {rd_ready_a, rd_ready_b}, 4'b1010);
    wr(0, 9, 32'h22);
    tick(); idle();
    #1;
    chk("w9_data", {rd_data_a[31:0], rd_data_b[31:0]}, {32'h22, 32'h22});
    chk("w9_rdy", {rd_ready_a, rd_ready_b}, 4'b1111);

    // both ports write x3: port 1 wins
    wr(0, 3, 32'hAAAA); wr(1, 3, 32'hBBBB);
    rd(3, 3);
    #1;
    chk("dual_byp_a", rd_data_a, {32'hBBBB, 32'hBBBB});
    tick(); idle();
    #1;
    chk("dual_a", rd_data_a, {32'hBBBB, 32'hBBBB});
    chk("dual_b", rd_data_b, {32'hBBBB, 32'hBBBB});
    wr(0, 3, 32'h1); wr(1, 4, 32'h2);
    rd(3, 4);
    tick(); idle();
    #1;
    chk("split_a", rd_data_a, {32'h2, 32'h1});
    chk("split_b", rd_data_b, {32'h2, 32'h1});

    // indices 25/26 exist in A (SIZE 32) but are out of range in B (SIZE 24)
    wr(0, 25, 32'h55); claim_en = 1'b1; claim_index = 26;
    rd(25, 26);
    tick(); idle();
    #1;
    chk("oor_data_a", rd_data_a[31:0], 32'h55);
    chk("oor_data_b", rd_data_b, 64'h0);
    chk("oor_rdy", {rd_ready_a, rd_ready_b}, 4'b0111);
    chk("oor_empty", {sb_empty_a, sb_empty_b}, 2'b01);

    // reset mid-operation with x7 pending; reset-cycle claim/write are dropped
    claim_en = 1'b1; claim_index = 7;
    tick(); idle();
    rd(5, 7);
    #1;
    chk("pre_rst_data", {rd_data_a[31:0], rd_data_b[31:0]}, {32'hDEADBEEF, 32'hDEADBEEF});
    chk("pre_rst_rdy", {rd_ready_a, rd_ready_b}, 4'b0101);
    reset = 1'b1; claim_en = 1'b1; claim_index = 8; wr(0, 5, 32'h77);
    tick(); idle();
    reset = 1'b0;
    rd(5, 8);
    #1;
    chk("mid_rst_data_a", rd_data_a, 64'h0);
    chk("mid_rst_data_b", rd_data_b, 64'h0);
    chk("mid_rst_rdy", {rd_ready_a, rd_ready_b}, 4'b1111);
    chk("mid_rst_empty", {sb_empty_a, sb_empty_b}, 2'b11);
    rd(7, 26);
    #1;
    chk("mid_rst_rdy7", {rd_ready_a, rd_ready_b}, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
